// File: rtl/timer_host_master_pkg.sv
// timer_host_master_pkg
//   Shared definitions for the interval-timer host master: slave register
//   indices, control words written to the timer, and the FSM state encoding.
package timer_host_master_pkg;

    // Interval-timer slave register map (word indices)
    localparam int unsigned REG_STATUS   = 0;
    localparam int unsigned REG_CONTROL  = 1;
    localparam int unsigned REG_PERIOD_L = 2;
    localparam int unsigned REG_PERIOD_H = 3;
    localparam int unsigned REG_SNAP_L   = 4;
    localparam int unsigned REG_SNAP_H   = 5;

    // Control register words: ITO | CONT | START, and STOP
    localparam logic [15:0] CTRL_START_CONT_ITO = 16'h0007;
    localparam logic [15:0] CTRL_STOP           = 16'h0008;

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtrl,
        StRun,
        StClrSt,
        StHold,
        StSnapWr,
        StRdL,
        StCapL,
        StCapH,
        StWrStop
    } state_e;

endpackage

// File: rtl/timer_host_master_if.sv
// timer_host_master_if
//   Avalon-MM bus between the host master and the interval-timer slave.
//   m_address/m_chipselect/m_write_n/m_writedata : master -> slave
//   m_readdata (fixed read latency 1), irq (level) : slave -> master
interface timer_host_master_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 16
) ();
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write_n;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              irq;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_readdata,
        input  irq
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_readdata,
        output irq
    );
endinterface

// File: rtl/timer_host_master.sv
// timer_host_master
//   Hardware host for the interval timer: programs the period, starts
//   continuous interrupting mode, services timeouts by clearing status,
//   counts ticks and takes on-demand counter snapshots.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   cfg_period        32-bit period, latched on an accepted cfg_start
//   cfg_start         pulse: program and start (IDLE only)
//   cfg_stop          pulse: stop (latched while not IDLE)
//   snap_req          pulse: snapshot request (latched while not IDLE)
//   busy, running     status decodes of the FSM state
//   tick, tick_count  one pulse and one count per serviced timeout
//   snap_value/valid  last snapshot and its update pulse
//   bus               Avalon-MM master side (registered outputs)
module timer_host_master
    import timer_host_master_pkg::*;
#(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    timer_host_master_if.master bus
);

    state_e      state_q;
    logic [31:0] period_q;
    logic        stop_pend_q;
    logic        snap_pend_q;
    logic [15:0] snap_lo_q;

    // A request arriving in the very RUN cycle is honoured at once, so a
    // simultaneous stop still beats an irq.
    logic stop_now;
    logic snap_now;
    assign stop_now = stop_pend_q | cfg_stop;
    assign snap_now = snap_pend_q | snap_req;

    assign busy    = (state_q != StIdle);
    assign running = state_q inside {StRun, StClrSt, StHold, StSnapWr,
                                     StRdL, StCapL, StCapH, StWrStop};

    // Bus outputs are loaded on the edge entering a state, so the bus cycle
    // is presented during that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            period_q         <= '0;
            stop_pend_q      <= 1'b0;
            snap_pend_q      <= 1'b0;
            snap_lo_q        <= '0;
            tick             <= 1'b0;
            tick_count       <= '0;
            snap_value       <= '0;
            snap_valid       <= 1'b0;
            bus.m_address    <= '0;
            bus.m_chipselect <= 1'b0;
            bus.m_write_n    <= 1'b1;
            bus.m_writedata  <= '0;
        end else begin
            bus.m_chipselect <= 1'b0;
            bus.m_write_n    <= 1'b1;
            tick             <= 1'b0;
            snap_valid       <= 1'b0;

            if (state_q != StIdle) begin
                if (cfg_stop) stop_pend_q <= 1'b1;
                if (snap_req) snap_pend_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        period_q         <= cfg_period;
                        stop_pend_q      <= cfg_stop;
                        bus.m_address    <= ADDR_W'(REG_PERIOD_L);
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_writedata  <= DATA_W'(cfg_period[15:0]);
                        state_q          <= StWrPl;
                    end
                end
                StWrPl: begin
                    bus.m_address    <= ADDR_W'(REG_PERIOD_H);
                    bus.m_chipselect <= 1'b1;
                    bus.m_write_n    <= 1'b0;
                    bus.m_writedata  <= DATA_W'(period_q[31:16]);
                    state_q          <= StWrPh;
                end
                StWrPh: begin
                    bus.m_address    <= ADDR_W'(REG_CONTROL);
                    bus.m_chipselect <= 1'b1;
                    bus.m_write_n    <= 1'b0;
                    bus.m_writedata  <= DATA_W'(CTRL_START_CONT_ITO);
                    state_q          <= StWrCtrl;
                end
                StWrCtrl: begin
                    state_q <= StRun;
                end
                StRun: begin
                    if (stop_now) begin
                        bus.m_address    <= ADDR_W'(REG_CONTROL);
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_writedata  <= DATA_W'(CTRL_STOP);
                        state_q          <= StWrStop;
                    end else if (bus.irq) begin
                        bus.m_address    <= ADDR_W'(REG_STATUS);
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_writedata  <= '0;
                        tick             <= 1'b1;
                        tick_count       <= tick_count + TICK_W'(1);
                        state_q          <= StClrSt;
                    end else if (snap_now) begin
                        bus.m_address    <= ADDR_W'(REG_SNAP_L);
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_writedata  <= '0;
                        state_q          <= StSnapWr;
                    end
                end
                StClrSt: begin
                    state_q <= StHold;
                end
                // irq is still high here until the status clear lands
                StHold: begin
                    state_q <= StRun;
                end
                StSnapWr: begin
                    bus.m_address    <= ADDR_W'(REG_SNAP_L);
                    bus.m_chipselect <= 1'b1;
                    state_q          <= StRdL;
                end
                StRdL: begin
                    bus.m_address    <= ADDR_W'(REG_SNAP_H);
                    bus.m_chipselect <= 1'b1;
                    state_q          <= StCapL;
                end
                StCapL: begin
                    snap_lo_q <= 16'(bus.m_readdata);
                    state_q   <= StCapH;
                end
                StCapH: begin
                    snap_value  <= {16'(bus.m_readdata), snap_lo_q};
                    snap_valid  <= 1'b1;
                    snap_pend_q <= 1'b0;
                    state_q     <= StRun;
                end
                StWrStop: begin
                    stop_pend_q <= 1'b0;
                    snap_pend_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
